// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud-divider derivation and
// default line settings, kept here so a future transmitter can reuse them.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 115_200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Integer divide; the receiver relies on the result being at least 4.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look active out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage pipeline;
  // blocking ones would collapse them into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, LSB first) with a level-type rx_done flag.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] data_8,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic rxd_sync;
  logic rxd_prev;
  logic start_edge;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rxd),
    .q     (rxd_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxd_prev <= 1'b1;
    else        rxd_prev <= rxd_sync;
  end

  assign start_edge = rxd_prev && !rxd_sync;

  rx_state_e        state, state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             sample;
  logic             take_bit;
  logic             load_byte;
  logic             flag_frame;
  logic             clear_done;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad;
  logic             flag_parity;
`endif

  // START samples mid-bit so every later full-bit sample lands mid-bit too.
  assign sample = (state == START) ? (baud_cnt == HALF_TC) : (baud_cnt == FULL_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    take_bit    = 1'b0;
    load_byte   = 1'b0;
    flag_frame  = 1'b0;
    clear_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
    flag_parity = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
          clear_done = 1'b1;
        end
      end
      START: begin
        if (sample) state_next = rxd_sync ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          take_bit = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) state_next = STOP;
      end
`endif
      STOP: begin
        if (sample) begin
          if (!rxd_sync) begin
            flag_frame = 1'b1;
            state_next = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad) begin
            flag_parity = 1'b1;
            state_next  = IDLE;
`endif
          end else begin
            load_byte  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      BREAK: begin
        if (rxd_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state entry and after each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (state_next != state || sample || state == IDLE || state == BREAK) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state != DATA) bit_idx <= '0;
      else if (take_bit) bit_idx <= bit_idx + 3'd1;
      if (take_bit) shift <= {rxd_sync, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bad <= 1'b0;
    end else if (state == START) begin
      parity_bad <= 1'b0;
    end else if (state == PARITY && sample) begin
      parity_bad <= rxd_sync != ((^shift) ^ (PARITY_ODD != 0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= flag_parity;
  end
`else
  assign parity_err = 1'b0;
`endif

  // rx_done is a level: set by a good stop bit, cleared by the next start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_8    <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= flag_frame;
      if (load_byte) begin
        data_8  <= shift;
        rx_done <= 1'b1;
      end else if (clear_done) begin
        rx_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: frames are pushed to a scoreboard as they
// are driven and compared when rx_done rises. Parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD       = 100;
  localparam int PARITY_ODD = 0;
  localparam int CPB        = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT    = 2 + 1 + CPB / 2 + 10 * CPB;
  localparam int EXP_PE = 1;
`else
  localparam int LAT    = 2 + 1 + CPB / 2 + 9 * CPB;
  localparam int EXP_PE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] data_8;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  uart_rx_byte #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .data_8     (data_8),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard, cycle counter and a model of the downstream 64-bit assembler.
  logic [7:0]  exp_q[$];
  int          cyc = 0;
  int          n_rise = 0;
  int          last_rise_cyc = 0;
  int          last_start_cyc = 0;
  int          fe_pulses = 0;
  int          fe_long = 0;
  int          pe_pulses = 0;
  logic        done_prev = 1'b0;
  logic        fe_prev = 1'b0;
  logic        pe_prev = 1'b0;
  logic [7:0]  data_hold = 8'h00;
  logic [63:0] asm_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done && !done_prev) begin
        n_rise        <= n_rise + 1;
        last_rise_cyc <= cyc;
        asm_word      <= {data_8, asm_word[63:8]};
        if (exp_q.size() == 0) check("unexpected_rx_done", 64'd1, 64'd0);
        else                   check("data_8", 64'(data_8), 64'(exp_q.pop_front()));
      end
      if (rx_done && done_prev && data_8 !== data_hold)
        check("data_8_stable", 64'(data_8), 64'(data_hold));
      if (frame_err) begin
        if (fe_prev) fe_long <= fe_long + 1;
        else         fe_pulses <= fe_pulses + 1;
      end
      if (parity_err && !pe_prev) pe_pulses <= pe_pulses + 1;
    end
    done_prev <= rx_done;
    fe_prev   <= frame_err;
    pe_prev   <= parity_err;
    data_hold <= data_8;
  end

  // Caller is at a negedge; returns at the negedge where the next frame may start.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic good;
    good = stop_bit;
`ifdef UART_RX_PARITY_EN
    good = good && (par_bit == ((^b) ^ (PARITY_ODD != 0)));
`endif
    if (good) exp_q.push_back(b);
    last_start_cyc = cyc;
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = par_bit;
    repeat (CPB) @(negedge clk);
`endif
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string tag);
    for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  int rise0;
  int fe0;
  int pe0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data_8", 64'(data_8), 64'h00);
    check("reset_rx_done", 64'(rx_done), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);
    check("reset_parity_err", 64'(parity_err), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("release_no_start", 64'(dut.state), 64'(IDLE));

    // Single frame with latency measurement.
    rise0 = n_rise;
    send_frame(8'hA5, 1'b1, (^8'hA5) ^ (PARITY_ODD != 0));
    drain("drain_a5");
    check("a5_one_edge", 64'(n_rise - rise0), 64'd1);
    check("a5_latency", 64'(last_rise_cyc - last_start_cyc), 64'(LAT));
    check("a5_value", 64'(data_8), 64'hA5);
    check("a5_no_frame_err", 64'(fe_pulses), 64'd0);

    // Back-to-back frames with no idle gap.
    rise0 = n_rise;
    send_frame(8'h12, 1'b1, (^8'h12) ^ (PARITY_ODD != 0));
    send_frame(8'h34, 1'b1, (^8'h34) ^ (PARITY_ODD != 0));
    drain("drain_b2b");
    check("b2b_two_edges", 64'(n_rise - rise0), 64'd2);

    // Three-cycle start glitch.
    rise0 = n_rise;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_edge", 64'(n_rise - rise0), 64'd0);
    check("glitch_no_err", 64'(fe_pulses), 64'd0);
    check("glitch_data_kept", 64'(data_8), 64'h34);
    check("glitch_idle", 64'(dut.state), 64'(IDLE));

    // Bad stop bit followed by a break, then a good frame.
    fe0 = fe_pulses;
    send_frame(8'h5A, 1'b0, (^8'h5A) ^ (PARITY_ODD != 0));
    repeat (15) @(negedge clk);
    check("break_data_kept", 64'(data_8), 64'h34);
    check("break_state", 64'(dut.state), 64'(BREAK));
    repeat (15) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("frame_err_pulses", 64'(fe_pulses - fe0), 64'd1);
    check("frame_err_width", 64'(fe_long), 64'd0);
    send_frame(8'h3C, 1'b1, (^8'h3C) ^ (PARITY_ODD != 0));
    drain("drain_3c");
    check("after_break_value", 64'(data_8), 64'h3C);

    // Reset in the middle of data bit 4.
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = 1'(8'h96 >> i);
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_data_8", 64'(data_8), 64'h00);
    check("async_rst_rx_done", 64'(rx_done), 64'd0);
    check("async_rst_state", 64'(dut.state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    rise0 = n_rise;
    repeat (2 * CPB) @(negedge clk);
    check("rst_no_spurious", 64'(n_rise - rise0), 64'd0);
    send_frame(8'h77, 1'b1, (^8'h77) ^ (PARITY_ODD != 0));
    drain("drain_77");
    check("after_rst_value", 64'(data_8), 64'h77);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 needs parity bit 0.
    pe0   = pe_pulses;
    rise0 = n_rise;
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("parity_err_pulse", 64'(pe_pulses - pe0), 64'd1);
    check("parity_bad_no_edge", 64'(n_rise - rise0), 64'd0);
    check("parity_bad_data_kept", 64'(data_8), 64'h77);
    send_frame(8'h03, 1'b1, 1'b0);
    drain("drain_parity_ok");
    check("parity_ok_edge", 64'(n_rise - rise0), 64'd1);
`endif

    // Eight frames into the downstream assembler model.
    rise0 = n_rise;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, (^8'(i)) ^ (PARITY_ODD != 0));
    drain("drain_asm");
    check("asm_edges", 64'(n_rise - rise0), 64'd8);
    check("asm_word", asm_word, 64'h0807060504030201);
    check("parity_err_total", 64'(pe_pulses), 64'(EXP_PE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver that deserialises the asynchronous `uart_rxd` line into bytes.
- Presents each byte on `data_8` together with a level-type completion flag, `rx_done`.
- Sits directly upstream of the 8-byte-to-64-bit assembler, which accumulates one byte per rising edge of its enable.
- Frame format: 8N1, LSB first, with optional parity.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (derived localparam): clock cycles per bit; must be ≥ 4.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rxd  input  1  serial line, idle high, asynchronous to clk.
- data_8  output  8  last correctly received byte.
- rx_done  output  1  byte-valid level; a rising edge marks a new byte.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- parity_err  output  1  one-cycle pulse on a parity mismatch; tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Interface: one clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values:
  - data_8 = 8'h00.
  - rx_done, frame_err, parity_err = 0.
  - State = IDLE; bit counter and baud counter = 0.
  - Both synchroniser flops = 1, so reset release never produces a false start edge.
- Input conditioning: `uart_rxd` passes through a 2-flop synchroniser plus one delay flop. A start edge is synced level 0 with the previous synced level 1.
- Baud counter rules:
  - Cleared on every state entry.
  - Counts 0..CLKS_PER_BIT-1.
  - A "sample" is the cycle where the count reaches its terminal value.
- State machine:
  - IDLE: on a start edge, go to START and clear rx_done in the same cycle.
  - START: sample at count CLKS_PER_BIT/2-1 (mid start bit).
    - Line 0: go to DATA with bit index 0.
    - Line 1: glitch; return to IDLE. rx_done stays 0 and no error is flagged.
  - DATA: sample at count CLKS_PER_BIT-1.
    - Shift the sampled bit into the MSB of the shift register (right shift, LSB first).
    - After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: sample at count CLKS_PER_BIT-1; compare against the XOR of the data bits (inverted when PARITY_ODD=1). Then go to STOP.
  - STOP: sample at count CLKS_PER_BIT-1.
    - Line 1 with parity OK: data_8 <= shift register and rx_done <= 1, registered on the next edge; go to IDLE.
    - Line 0: frame_err pulses for 1 cycle; go to BREAK.
    - Parity bad: parity_err pulses for 1 cycle; go to IDLE.
    - In both error cases data_8 and rx_done are not updated.
  - BREAK: wait for the synced line to return to 1, then go to IDLE. No start edge is accepted while in BREAK.
- rx_done is a level:
  - Held 1 from a good stop sample until the next accepted start edge.
  - It is therefore low for at least CLKS_PER_BIT/2 cycles before any subsequent rise.
  - The downstream edge detector sees exactly one rising edge per good byte.
- data_8 is stable whenever rx_done = 1.
- Latency: rx_done rises 1 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start edge is seen in synced form (add CLKS_PER_BIT with parity).
- Back-to-back frames: the IDLE re-entry at mid stop bit leaves at least half a bit to catch the next start edge.
- Reset mid-frame: the partial byte is discarded and all outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and one bit time per frame.
  - parity_err is live.
  - A mismatched byte is dropped: no rx_done edge and no data_8 update.
- Undefined:
  - 8N1 only; the PARITY state is absent.
  - parity_err is driven constant 0; the port remains for a stable interface.

Decomposition:
- Shared package/include `uart_pkg`:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP, BREAK (3-bit).
  - The CLKS_PER_BIT derivation function.
  - The default CLK_FREQ and BAUD values, for reuse by the future transmitter.
- Sub-module `sync_2ff`:
  - Parameterised reset value (1 here).
  - Reusable for every asynchronous input in the design.
- The baud counter stays inline.

Test Plan:
- Common setup: CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10).
1. Frame 0xA5 (8N1):
   - data_8 = 8'hA5 and exactly one rx_done rising edge, 1+5+90 cycles after the synced start edge.
   - frame_err and parity_err stay 0.
2. Back-to-back frames 0x12 then 0x34, no idle gap:
   - Two rx_done rising edges, with rx_done low between them.
   - data_8 = 8'h12, then 8'h34.
3. Start-bit glitch of 3 cycles low, then line high:
   - No rx_done edge, no error pulse, data_8 unchanged, FSM returns to IDLE.
4. Frame 0x5A with stop bit 0, line held low for 30 cycles, then valid frame 0x3C:
   - frame_err is a single-cycle pulse; data_8 keeps its prior value during the break.
   - Afterwards 0x3C is received normally.
5. rst_n asserted in the middle of DATA bit 4:
   - All outputs return to 0 immediately; no spurious rx_done after release.
   - A next frame 0x77 is received correctly.
6. With UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x03 with parity bit 1:
   - parity_err pulses and no rx_done edge.
   - The same frame with parity bit 0 gives data_8 = 8'h03 with an rx_done edge.
   - Integration: eight frames 0x01..0x08 into the downstream assembler yield 64'h0807060504030201.
